// File: rtl/axil_reg_slave.sv
// AXI4-Lite register bank: ID, scratch, control, W1C interrupt status with
// enable mask, live status and NUM_USER user registers. Write address and
// write data are captured independently, then committed together on the
// following edge; read data is captured at the AR handshake.
module axil_reg_slave #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned NUM_USER   = 8,
  parameter logic [31:0] ID_VALUE   = 32'h5246_0001
) (
  input  logic                   axilite_clk,
  input  logic                   axilite_rst,
  input  logic [ADDR_WIDTH-1:0]  s_axil_awaddr,
  input  logic [2:0]             s_axil_awprot,
  input  logic                   s_axil_awvalid,
  output logic                   s_axil_awready,
  input  logic [31:0]            s_axil_wdata,
  input  logic [3:0]             s_axil_wstrb,
  input  logic                   s_axil_wvalid,
  output logic                   s_axil_wready,
  output logic [1:0]             s_axil_bresp,
  output logic                   s_axil_bvalid,
  input  logic                   s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]  s_axil_araddr,
  input  logic [2:0]             s_axil_arprot,
  input  logic                   s_axil_arvalid,
  output logic                   s_axil_arready,
  output logic [31:0]            s_axil_rdata,
  output logic [1:0]             s_axil_rresp,
  output logic                   s_axil_rvalid,
  input  logic                   s_axil_rready,
  input  logic [31:0]            status_in,
  input  logic [7:0]             irq_in,
  output logic [31:0]            ctrl_out,
  output logic [32*NUM_USER-1:0] user_out,
  output logic                   irq
);

  localparam int unsigned IW = ADDR_WIDTH - 2;
  localparam int unsigned UW = (NUM_USER > 1) ? $clog2(NUM_USER) : 1;

  localparam logic [IW-1:0] IDX_ID    = IW'(0);
  localparam logic [IW-1:0] IDX_SCR   = IW'(1);
  localparam logic [IW-1:0] IDX_CTRL  = IW'(2);
  localparam logic [IW-1:0] IDX_IST   = IW'(3);
  localparam logic [IW-1:0] IDX_IEN   = IW'(4);
  localparam logic [IW-1:0] IDX_STAT  = IW'(5);
  localparam logic [IW-1:0] IDX_USER  = IW'(16);
  localparam logic [IW-1:0] IDX_UEND  = IW'(16 + NUM_USER);

  logic          aw_held_q;
  logic [IW-1:0] aw_idx_q;
  logic          w_held_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic          bvalid_q;
  logic [1:0]    bresp_q;
  logic          rvalid_q;
  logic [31:0]   rdata_q;
  logic [1:0]    rresp_q;

  logic [31:0]   scratch_q;
  logic [31:0]   ctrl_q;
  logic [7:0]    irq_status_q;
  logic [7:0]    irq_enable_q;
  logic          irq_q;
  logic [31:0]   user_q [NUM_USER];

  logic          commit;
  logic [IW-1:0] rd_idx;
  logic [UW-1:0] rd_uidx;
  logic [31:0]   rd_data;
  logic          rd_ok;
  logic [UW-1:0] wr_uidx;
  logic [31:0]   wr_old;
  logic [31:0]   wr_merged;
  logic          wr_ok;
  logic          wr_user;
  logic [7:0]    irq_clr;

  logic unused_ok;
  assign unused_ok = ^{s_axil_awprot, s_axil_arprot,
                       s_axil_awaddr[1:0], s_axil_araddr[1:0]};

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int unsigned b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  // Ready is withheld while a slot is full, and during reset itself.
  assign s_axil_awready = ~axilite_rst & ~aw_held_q & ~bvalid_q;
  assign s_axil_wready  = ~axilite_rst & ~w_held_q  & ~bvalid_q;
  assign s_axil_arready = ~axilite_rst & ~rvalid_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign ctrl_out       = ctrl_q;
  assign irq            = irq_q;
  assign commit         = aw_held_q & w_held_q;

  // Flatten the user register array onto the output bus.
  always_comb begin
    user_out = '0;
    for (int unsigned i = 0; i < NUM_USER; i++) begin
      user_out[32*i +: 32] = user_q[i];
    end
  end

  // Read decode against the live AR address.
  always_comb begin
    rd_idx  = s_axil_araddr[ADDR_WIDTH-1:2];
    rd_uidx = UW'(rd_idx - IDX_USER);
    rd_data = '0;
    rd_ok   = 1'b1;
    case (rd_idx)
      IDX_ID:   rd_data = ID_VALUE;
      IDX_SCR:  rd_data = scratch_q;
      IDX_CTRL: rd_data = ctrl_q;
      IDX_IST:  rd_data = {24'd0, irq_status_q};
      IDX_IEN:  rd_data = {24'd0, irq_enable_q};
      IDX_STAT: rd_data = status_in;
      default: begin
        if (rd_idx >= IDX_USER && rd_idx < IDX_UEND) rd_data = user_q[rd_uidx];
        else rd_ok = 1'b0;
      end
    endcase
  end

  // Write decode against the held AW address; RO registers decode as mapped.
  always_comb begin
    wr_uidx = UW'(aw_idx_q - IDX_USER);
    wr_old  = '0;
    wr_ok   = 1'b1;
    wr_user = 1'b0;
    case (aw_idx_q)
      IDX_ID, IDX_STAT, IDX_IST: wr_old = '0;
      IDX_SCR:  wr_old = scratch_q;
      IDX_CTRL: wr_old = ctrl_q;
      IDX_IEN:  wr_old = {24'd0, irq_enable_q};
      default: begin
        if (aw_idx_q >= IDX_USER && aw_idx_q < IDX_UEND) begin
          wr_old  = user_q[wr_uidx];
          wr_user = 1'b1;
        end else begin
          wr_ok = 1'b0;
        end
      end
    endcase
    wr_merged = merge_bytes(wr_old, wdata_q, wstrb_q);
    irq_clr   = (commit && aw_idx_q == IDX_IST && wstrb_q[0]) ? wdata_q[7:0] : '0;
  end

  // Write channel: independent AW/W capture, commit, and B response.
  always_ff @(posedge axilite_clk) begin
    if (axilite_rst) begin
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      if (s_axil_awvalid && s_axil_awready) begin
        aw_held_q <= 1'b1;
        aw_idx_q  <= s_axil_awaddr[ADDR_WIDTH-1:2];
      end
      if (s_axil_wvalid && s_axil_wready) begin
        w_held_q <= 1'b1;
        wdata_q  <= s_axil_wdata;
        wstrb_q  <= s_axil_wstrb;
      end
      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= wr_ok ? 2'b00 : 2'b10;
      end else if (bvalid_q && s_axil_bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Register bank updates; an incoming irq_in pulse beats a same-edge W1C clear.
  always_ff @(posedge axilite_clk) begin
    if (axilite_rst) begin
      scratch_q    <= '0;
      ctrl_q       <= '0;
      irq_status_q <= '0;
      irq_enable_q <= '0;
      irq_q        <= 1'b0;
      for (int unsigned i = 0; i < NUM_USER; i++) user_q[i] <= '0;
    end else begin
      if (commit) begin
        if (aw_idx_q == IDX_SCR)  scratch_q    <= wr_merged;
        if (aw_idx_q == IDX_CTRL) ctrl_q       <= wr_merged;
        if (aw_idx_q == IDX_IEN)  irq_enable_q <= wr_merged[7:0];
        if (wr_user)              user_q[wr_uidx] <= wr_merged;
      end
      irq_status_q <= (irq_status_q & ~irq_clr) | irq_in;
      irq_q        <= |(irq_status_q & irq_enable_q);
    end
  end

  // Read channel: capture at the AR handshake, hold until R handshake.
  always_ff @(posedge axilite_clk) begin
    if (axilite_rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= 2'b00;
    end else if (s_axil_arvalid && s_axil_arready) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data;
      rresp_q  <= rd_ok ? 2'b00 : 2'b10;
    end else if (rvalid_q && s_axil_rready) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Bench for axil_reg_slave: directed AXI4-Lite transactions, a transaction
// level model of the register map compared every cycle, and literal checks.
module tb_axil_reg_slave;

  localparam int NU = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [11:0]   awaddr = '0;
  logic [2:0]    awprot = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;
  logic [11:0]   araddr = '0;
  logic [2:0]    arprot = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready = 1'b0;
  logic [31:0]   status_in = 32'hC0FF_EE00;
  logic [7:0]    irq_in = '0;
  logic [31:0]   ctrl_out;
  logic [32*NU-1:0] user_out;
  logic          irq;

  always #5 clk = ~clk;

  axil_reg_slave #(
    .ADDR_WIDTH(12),
    .NUM_USER(NU),
    .ID_VALUE(32'h5246_0001)
  ) dut (
    .axilite_clk(clk), .axilite_rst(rst),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid),
    .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid),
    .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid),
    .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid),
    .s_axil_rready(rready),
    .status_in(status_in), .irq_in(irq_in),
    .ctrl_out(ctrl_out), .user_out(user_out), .irq(irq)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [31:0] m_scr, m_ctrl;
  logic [7:0]  m_ist, m_ien;
  logic [31:0] m_user [NU];
  logic        m_irq;
  logic        m_aw, m_w, m_bpend, m_rpend;
  logic [11:0] m_awaddr;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  task automatic model_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] r);
    int unsigned al;
    al = 32'(a) & 32'hFFC;
    r = 2'b00;
    d = '0;
    if      (al == 32'h000) d = 32'h5246_0001;
    else if (al == 32'h004) d = m_scr;
    else if (al == 32'h008) d = m_ctrl;
    else if (al == 32'h00C) d = {24'd0, m_ist};
    else if (al == 32'h010) d = {24'd0, m_ien};
    else if (al == 32'h014) d = status_in;
    else if (al >= 32'h040 && al < 32'h040 + 4 * NU) d = m_user[(al - 32'h040) / 4];
    else r = 2'b10;
  endtask

  task automatic model_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] r, output logic [7:0] clr);
    int unsigned al;
    logic [31:0] mk;
    al  = 32'(a) & 32'hFFC;
    mk  = lane_mask(s);
    r   = 2'b00;
    clr = '0;
    if      (al == 32'h004) m_scr  = (m_scr & ~mk) | (d & mk);
    else if (al == 32'h008) m_ctrl = (m_ctrl & ~mk) | (d & mk);
    else if (al == 32'h00C) clr = s[0] ? d[7:0] : 8'h00;
    else if (al == 32'h010) m_ien = s[0] ? d[7:0] : m_ien;
    else if (al == 32'h000 || al == 32'h014) r = 2'b00;
    else if (al >= 32'h040 && al < 32'h040 + 4 * NU)
      m_user[(al - 32'h040) / 4] = (m_user[(al - 32'h040) / 4] & ~mk) | (d & mk);
    else r = 2'b10;
  endtask

  task automatic model_step();
    logic awr, wr, irq_next;
    logic [7:0] clr;
    if (rst) begin
      m_scr = '0; m_ctrl = '0; m_ist = '0; m_ien = '0; m_irq = 1'b0;
      for (int i = 0; i < NU; i++) m_user[i] = '0;
      m_aw = 1'b0; m_w = 1'b0; m_bpend = 1'b0; m_rpend = 1'b0;
      m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0;
      return;
    end
    awr = !m_aw && !m_bpend;
    wr  = !m_w && !m_bpend;
    irq_next = |(m_ist & m_ien);
    clr = '0;
    if (m_rpend) begin
      if (rready) m_rpend = 1'b0;
    end else if (arvalid) begin
      model_read(araddr, m_rdata, m_rresp);
      m_rpend = 1'b1;
    end
    if (m_aw && m_w) begin
      model_write(m_awaddr, m_wdata, m_wstrb, m_bresp, clr);
      m_aw = 1'b0; m_w = 1'b0; m_bpend = 1'b1;
    end else if (m_bpend && bready) begin
      m_bpend = 1'b0;
    end
    if (awr && awvalid) begin m_aw = 1'b1; m_awaddr = awaddr; end
    if (wr && wvalid) begin m_w = 1'b1; m_wdata = wdata; m_wstrb = wstrb; end
    m_ist = (m_ist & ~clr) | irq_in;
    m_irq = irq_next;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison of DUT outputs against the model.
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      check1("awready", awready, !rst && !m_aw && !m_bpend);
      check1("wready",  wready,  !rst && !m_w && !m_bpend);
      check1("arready", arready, !rst && !m_rpend);
      check1("bvalid",  bvalid,  m_bpend);
      if (m_bpend) check("bresp", {30'd0, bresp}, {30'd0, m_bresp});
      check1("rvalid",  rvalid,  m_rpend);
      if (m_rpend) begin
        check("rdata", rdata, m_rdata);
        check("rresp", {30'd0, rresp}, {30'd0, m_rresp});
      end
      check("ctrl_out", ctrl_out, m_ctrl);
      check1("irq", irq, m_irq);
      for (int i = 0; i < NU; i++) check($sformatf("user%0d", i), user_out[32*i +: 32], m_user[i]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n;
    bit aw_done, w_done, got;
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; got = 1'b0; n = 0; resp = 2'bxx;
    while (!(aw_done && w_done) && n < 40) begin
      @(negedge clk);
      if (awvalid && awready) aw_done = 1'b1;
      if (wvalid && wready) w_done = 1'b1;
      cyc(1);
      if (aw_done) awvalid = 1'b0;
      if (w_done) wvalid = 1'b0;
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    bready = 1'b1; n = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      if (bvalid) begin got = 1'b1; resp = bresp; end
      cyc(1);
      n++;
    end
    bready = 1'b0;
    check1("write_completes", aw_done && w_done && got, 1'b1);
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    bit ar_done, got;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    ar_done = 1'b0; got = 1'b0; n = 0; d = 'x; resp = 2'bxx;
    while (!ar_done && n < 40) begin
      @(negedge clk);
      if (arready) ar_done = 1'b1;
      cyc(1);
      n++;
    end
    arvalid = 1'b0; n = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      if (rvalid) begin got = 1'b1; d = rdata; resp = rresp; end
      cyc(1);
      n++;
    end
    rready = 1'b0;
    check1("read_completes", ar_done && got, 1'b1);
  endtask

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed tests ----------------
  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int cnt;

    // 1: reset and ID readback
    @(posedge clk); #2;
    cmp_en = 1'b1;
    cyc(2);
    @(negedge clk);
    check1("rst_awready", awready, 1'b0);
    check1("rst_arready", arready, 1'b0);
    cyc(1);
    rst = 1'b0;
    @(negedge clk);
    check1("rel_awready", awready, 1'b1);
    check1("rel_wready",  wready,  1'b1);
    check1("rel_arready", arready, 1'b1);
    check("rel_ctrl", ctrl_out, 32'h0);
    check1("rel_irq", irq, 1'b0);
    cyc(1);
    axi_read(12'h000, d, r);
    check("id_rdata", d, 32'h5246_0001);
    check("id_rresp", {30'd0, r}, 32'd0);
    axi_read(12'h014, d, r);
    check("status_rdata", d, 32'hC0FF_EE00);

    // 2: scratch full and partial writes
    axi_write(12'h004, 32'hA5A5_5A5A, 4'hF, r);
    check("scr_bresp", {30'd0, r}, 32'd0);
    axi_read(12'h004, d, r);
    check("scr_rd1", d, 32'hA5A5_5A5A);
    axi_write(12'h004, 32'hFFFF_FFFF, 4'b0011, r);
    axi_read(12'h004, d, r);
    check("scr_rd2", d, 32'hA5A5_FFFF);

    // 3: W three cycles ahead of AW
    awaddr = 12'h008; wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    check1("t3_wready", wready, 1'b1);
    cyc(1);
    wvalid = 1'b0;
    @(negedge clk);
    check1("t3_wready_drop", wready, 1'b0);
    cyc(2);
    awvalid = 1'b1;
    @(negedge clk);
    check1("t3_awready", awready, 1'b1);
    cyc(1);
    awvalid = 1'b0;
    @(negedge clk);
    check1("t3_b_not_yet", bvalid, 1'b0);
    cyc(1);
    @(negedge clk);
    check1("t3_b_rise", bvalid, 1'b1);
    check("t3_ctrl", ctrl_out, 32'h1234_5678);
    bready = 1'b1;
    cnt = 0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      if (bvalid) cnt++;
    end
    check("t3_single_b", cnt, 32'd0);
    cyc(1);
    bready = 1'b0;

    // 4: interrupt set, set-beats-clear, clear
    axi_write(12'h010, 32'h0000_0001, 4'hF, r);
    irq_in = 8'h01;
    cyc(1);
    irq_in = 8'h00;
    @(negedge clk);
    check1("t4_irq_lag", irq, 1'b0);
    cyc(1);
    @(negedge clk);
    check1("t4_irq_set", irq, 1'b1);
    cyc(1);
    awaddr = 12'h00C; wdata = 32'h1; wstrb = 4'b0001; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    check1("t4_both_ready", awready && wready, 1'b1);
    cyc(1);
    awvalid = 1'b0; wvalid = 1'b0; irq_in = 8'h01; bready = 1'b1;
    cyc(1);
    irq_in = 8'h00;
    @(negedge clk);
    check1("t4_b_after_clr", bvalid, 1'b1);
    cyc(1);
    bready = 1'b0;
    cyc(2);
    @(negedge clk);
    check1("t4_irq_kept", irq, 1'b1);
    cyc(1);
    axi_read(12'h00C, d, r);
    check("t4_ist_kept", d, 32'h1);
    axi_write(12'h00C, 32'h1, 4'b0001, r);
    cyc(1);
    @(negedge clk);
    check1("t4_irq_cleared", irq, 1'b0);
    cyc(1);
    axi_read(12'h00C, d, r);
    check("t4_ist_zero", d, 32'h0);

    // 5: unmapped, RO and user accesses
    axi_read(12'hFFC, d, r);
    check("t5_unm_rdata", d, 32'h0);
    check("t5_unm_rresp", {30'd0, r}, 32'd2);
    axi_write(12'hFFC, 32'hDEAD_BEEF, 4'hF, r);
    check("t5_unm_bresp", {30'd0, r}, 32'd2);
    axi_write(12'h000, 32'hDEAD_BEEF, 4'hF, r);
    check("t5_ro_bresp", {30'd0, r}, 32'd0);
    axi_read(12'h000, d, r);
    check("t5_id_kept", d, 32'h5246_0001);
    axi_read(12'h004, d, r);
    check("t5_scr_kept", d, 32'hA5A5_FFFF);
    axi_write(12'h044, 32'hCAFE_F00D, 4'hF, r);
    axi_read(12'h044, d, r);
    check("t5_user1_rd", d, 32'hCAFE_F00D);
    check("t5_user1_out", user_out[63:32], 32'hCAFE_F00D);

    // 6: B back-pressure, then reset with bvalid pending
    awaddr = 12'h004; wdata = 32'h1111_2222; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    cyc(1);
    awvalid = 1'b0; wvalid = 1'b0;
    cyc(1);
    awaddr = 12'h008; wdata = 32'h0000_0099; awvalid = 1'b1; wvalid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check1("t6_bvalid_hold", bvalid, 1'b1);
      check("t6_bresp_hold", {30'd0, bresp}, 32'd0);
      check1("t6_awready_low", awready, 1'b0);
      cyc(1);
    end
    check("t6_ctrl_unchanged", ctrl_out, 32'h1234_5678);
    rst = 1'b1;
    cyc(1);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check1("t6_b_reset", bvalid, 1'b0);
    check("t6_ctrl_reset", ctrl_out, 32'h0);
    cyc(1);
    rst = 1'b0;
    @(negedge clk);
    check1("t6_awready_rel", awready, 1'b1);
    cyc(1);
    axi_read(12'h004, d, r);
    check("t6_scr_reset", d, 32'h0);
    cyc(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
